// File: rtl/core2wb_pipe_if.sv
// Wishbone B4 pipelined bus bundle used by core2wb_pipe.
// Signal names follow the master's point of view: wb_dat_o is master write data,
// wb_dat_i is slave read data.
interface core2wb_pipe_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [DW/8-1:0]   wb_sel;
  logic [AW-1:0]     wb_adr;
  logic [DW-1:0]     wb_dat_o;
  logic              wb_stall;
  logic              wb_ack;
  logic              wb_err;
  logic [DW-1:0]     wb_dat_i;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o,
    input  wb_stall, wb_ack, wb_err, wb_dat_i
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o,
    output wb_stall, wb_ack, wb_err, wb_dat_i
  );
endinterface

// File: rtl/core2wb_pipe.sv
// Ibex req/gnt/rvalid memory port to Wishbone B4 pipelined master bridge.
// Up to MaxOutstanding transfers in flight; a watchdog (TimeoutCycles, 0 = off)
// flushes hung transfers with error responses.
// Optional statistics counters: define CORE2WB_PIPE_STATS_EN.
module core2wb_pipe #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  // Core side
  input  logic              core_req,
  output logic              core_gnt,
  input  logic              core_we,
  input  logic [DW/8-1:0]   core_be,
  input  logic [AW-1:0]     core_addr,
  input  logic [DW-1:0]     core_wdata,
  output logic              core_rvalid,
  output logic [DW-1:0]     core_rdata,
  output logic              core_err,
  // Bus side
  core2wb_pipe_if.master    wb,
  // Statistics
  output logic [31:0]       stat_txn,
  output logic [15:0]       stat_err,
  output logic [15:0]       stat_tmo
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned WdW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);
  localparam logic [WdW-1:0]  WdLast = WdW'(TimeoutCycles - 1);
  localparam bit              TmoEn  = (TimeoutCycles != 0);

  typedef enum logic [1:0] {StIdle, StBusy, StFlush} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic flush;
  logic resp_acc;
  logic flush_rsp;
  logic tmo_fire;

  assign flush     = (state_q == StFlush);
  // Responses only count while something is in flight and we are not draining.
  assign resp_acc  = (wb.wb_ack || wb.wb_err) && (outst_q != '0) && !flush;
  assign flush_rsp = flush && (outst_q != '0);

  // Request path is purely combinational; the outstanding limit uses the
  // registered count so an ack never opens a grant in the same cycle.
  assign wb.wb_adr   = core_addr;
  assign wb.wb_dat_o = core_wdata;
  assign wb.wb_sel   = core_be;
  assign wb.wb_we    = core_we;
  assign wb.wb_stb   = core_req && !flush && (outst_q < MaxOut);
  assign core_gnt    = wb.wb_stb && !wb.wb_stall;
  assign wb.wb_cyc   = !flush && (wb.wb_stb || (outst_q != '0));

  assign core_rvalid = rvalid_q;
  assign core_err    = err_q;
  assign core_rdata  = rdata_q;

  // Next-state: outstanding count, watchdog, FSM and registered response.
  always_comb begin
    state_d  = state_q;
    outst_d  = outst_q;
    wd_d     = wd_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    tmo_fire = 1'b0;

    unique case ({core_gnt, resp_acc || flush_rsp})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    if (resp_acc) begin
      rvalid_d = 1'b1;
      err_d    = wb.wb_err;  // ack+err together is an error
      rdata_d  = wb.wb_dat_i;
    end else if (flush_rsp) begin
      rvalid_d = 1'b1;
      err_d    = 1'b1;
      rdata_d  = '0;
    end

    unique case (state_q)
      StIdle: begin
        wd_d = '0;
        if (core_gnt) state_d = StBusy;
      end
      StBusy: begin
        if (resp_acc) begin
          wd_d = '0;
          if (outst_d == '0) state_d = StIdle;
        end else if (TmoEn && (wd_q == WdLast)) begin
          wd_d     = '0;
          state_d  = StFlush;
          tmo_fire = 1'b1;
        end else if (TmoEn) begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StFlush: begin
        wd_d = '0;
        if (outst_d == '0) state_d = StIdle;
      end
      default: begin
        wd_d    = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops all in-flight transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      outst_q  <= '0;
      wd_q     <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      outst_q  <= outst_d;
      wd_q     <= wd_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef CORE2WB_PIPE_STATS_EN
  logic [31:0] stat_txn_q;
  logic [15:0] stat_err_q;
  logic [15:0] stat_tmo_q;

  // Statistics track the response about to be presented to the core.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_txn_q <= '0;
      stat_err_q <= '0;
      stat_tmo_q <= '0;
    end else begin
      if (rvalid_d) stat_txn_q <= stat_txn_q + 32'd1;
      if (rvalid_d && err_d && (stat_err_q != 16'hFFFF)) stat_err_q <= stat_err_q + 16'd1;
      if (tmo_fire && (stat_tmo_q != 16'hFFFF)) stat_tmo_q <= stat_tmo_q + 16'd1;
    end
  end

  assign stat_txn = stat_txn_q;
  assign stat_err = stat_err_q;
  assign stat_tmo = stat_tmo_q;
`else
  logic unused_tmo_fire;
  assign unused_tmo_fire = tmo_fire;
  assign stat_txn = '0;
  assign stat_err = '0;
  assign stat_tmo = '0;
`endif

endmodule

// File: tb/tb_core2wb_pipe.sv
// Directed bench for core2wb_pipe with a response scoreboard.
module tb_core2wb_pipe;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req;
  logic          core_gnt;
  logic          core_we;
  logic [3:0]    core_be;
  logic [31:0]   core_addr;
  logic [31:0]   core_wdata;
  logic          core_rvalid;
  logic [31:0]   core_rdata;
  logic          core_err;
  logic [31:0]   stat_txn;
  logic [15:0]   stat_err;
  logic [15:0]   stat_tmo;

  core2wb_pipe_if #(.AW(AW), .DW(DW)) wb_if ();

  core2wb_pipe #(
    .AW             (AW),
    .DW             (DW),
    .MaxOutstanding (2),
    .TimeoutCycles  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_req    (core_req),
    .core_gnt    (core_gnt),
    .core_we     (core_we),
    .core_be     (core_be),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .core_err    (core_err),
    .wb          (wb_if.master),
    .stat_txn    (stat_txn),
    .stat_err    (stat_err),
    .stat_tmo    (stat_tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_r;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_txn = 0;
  int   exp_err = 0;
  int   exp_tmo = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    exp_q.push_back({d, e});
    exp_txn++;
    if (e) exp_err++;
  endtask

  // Start a new cycle (drive point) and move to the sampling point.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_stats(input string tag);
`ifdef CORE2WB_PIPE_STATS_EN
    chk({tag, "_txn"}, 64'(stat_txn), 64'(exp_txn));
    chk({tag, "_err"}, 64'(stat_err), 64'(exp_err));
    chk({tag, "_tmo"}, 64'(stat_tmo), 64'(exp_tmo));
`else
    chk({tag, "_txn"}, 64'(stat_txn), 64'd0);
    chk({tag, "_err"}, 64'(stat_err), 64'd0);
    chk({tag, "_tmo"}, 64'(stat_tmo), 64'd0);
`endif
  endtask

  // Scoreboard: every response must match the oldest expected one.
  always @(negedge clk) begin
    if (core_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rvalid", 64'(core_rvalid), 64'd0);
      end else begin
        mon_r = exp_q.pop_front();
        chk("rsp_rdata", 64'(core_rdata), 64'(mon_r.data));
        chk("rsp_err", 64'(core_err), 64'(mon_r.err));
      end
    end
  end

  initial begin
    rst_n             = 1'b0;
    core_req          = 1'b0;
    core_we           = 1'b0;
    core_be           = 4'hF;
    core_addr         = '0;
    core_wdata        = '0;
    wb_if.wb_stall    = 1'b0;
    wb_if.wb_ack      = 1'b0;
    wb_if.wb_err      = 1'b0;
    wb_if.wb_dat_i    = '0;

    // Reset state
    next();
    next();
    mid();
    chk("rst_cyc", 64'(wb_if.wb_cyc), 64'd0);
    chk("rst_stb", 64'(wb_if.wb_stb), 64'd0);
    chk("rst_gnt", 64'(core_gnt), 64'd0);
    chk("rst_rvalid", 64'(core_rvalid), 64'd0);
    chk("rst_err", 64'(core_err), 64'd0);
    chk("rst_rdata", 64'(core_rdata), 64'd0);
    chk_stats("rst");

    // Single read, ack one cycle after strobe
    next(); rst_n = 1'b1; core_req = 1'b1; core_addr = 32'h100;
    mid();
    chk("t1_gnt", 64'(core_gnt), 64'd1);
    chk("t1_stb", 64'(wb_if.wb_stb), 64'd1);
    chk("t1_cyc0", 64'(wb_if.wb_cyc), 64'd1);
    chk("t1_adr", 64'(wb_if.wb_adr), 64'h100);
    next(); core_req = 1'b0; wb_if.wb_ack = 1'b1; wb_if.wb_dat_i = 32'hDEADBEEF;
    push(32'hDEADBEEF, 1'b0);
    mid();
    chk("t1_rvalid1", 64'(core_rvalid), 64'd0);
    chk("t1_cyc1", 64'(wb_if.wb_cyc), 64'd1);
    next(); wb_if.wb_ack = 1'b0; wb_if.wb_dat_i = '0;
    mid();
    chk("t1_rvalid2", 64'(core_rvalid), 64'd1);
    chk("t1_cyc2", 64'(wb_if.wb_cyc), 64'd0);

    // Back-to-back, ack latency 3, third request held at the limit
    next(); core_req = 1'b1; core_addr = 32'h1000;
    mid();
    chk("t2_gnt0", 64'(core_gnt), 64'd1);
    next(); core_addr = 32'h1004;
    mid();
    chk("t2_gnt1", 64'(core_gnt), 64'd1);
    next(); core_addr = 32'h1008;
    mid();
    chk("t2_stb2", 64'(wb_if.wb_stb), 64'd0);
    chk("t2_gnt2", 64'(core_gnt), 64'd0);
    next(); wb_if.wb_ack = 1'b1; wb_if.wb_dat_i = 32'h1111_0000;
    push(32'h1111_0000, 1'b0);
    mid();
    chk("t2_stb3_blocked", 64'(wb_if.wb_stb), 64'd0);
    next(); wb_if.wb_dat_i = 32'h2222_0000;
    push(32'h2222_0000, 1'b0);
    mid();
    chk("t2_gnt4", 64'(core_gnt), 64'd1);
    chk("t2_rvalid4", 64'(core_rvalid), 64'd1);
    next(); core_req = 1'b0; wb_if.wb_ack = 1'b0;
    mid();
    chk("t2_rvalid5", 64'(core_rvalid), 64'd1);
    next();
    mid();
    chk("t2_cyc6", 64'(wb_if.wb_cyc), 64'd1);
    next(); wb_if.wb_ack = 1'b1; wb_if.wb_dat_i = 32'h3333_0000;
    push(32'h3333_0000, 1'b0);
    mid();
    next(); wb_if.wb_ack = 1'b0;
    mid();
    chk("t2_rvalid8", 64'(core_rvalid), 64'd1);
    chk("t2_cyc8", 64'(wb_if.wb_cyc), 64'd0);
    next();
    mid();
    chk_stats("t2");

    // Stalled write
    next(); core_req = 1'b1; core_we = 1'b1; core_be = 4'b0011;
    core_addr = 32'h200; core_wdata = 32'hCAFEF00D; wb_if.wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next();
      mid();
      chk("t3_stb", 64'(wb_if.wb_stb), 64'd1);
      chk("t3_gnt", 64'(core_gnt), 64'd0);
      chk("t3_adr", 64'(wb_if.wb_adr), 64'h200);
      chk("t3_dat", 64'(wb_if.wb_dat_o), 64'hCAFEF00D);
    end
    next(); wb_if.wb_stall = 1'b0;
    mid();
    chk("t3_gnt5", 64'(core_gnt), 64'd1);
    chk("t3_we", 64'(wb_if.wb_we), 64'd1);
    chk("t3_sel", 64'(wb_if.wb_sel), 64'h3);
    next(); core_req = 1'b0; core_we = 1'b0; core_be = 4'hF;
    wb_if.wb_ack = 1'b1; wb_if.wb_dat_i = '0;
    push(32'h0, 1'b0);
    mid();
    next(); wb_if.wb_ack = 1'b0;
    mid();
    chk("t3_rvalid", 64'(core_rvalid), 64'd1);

    // Error on the second of two reads
    next(); core_req = 1'b1; core_addr = 32'h300;
    mid();
    chk("t4_gnt0", 64'(core_gnt), 64'd1);
    next(); core_addr = 32'h304; wb_if.wb_ack = 1'b1; wb_if.wb_dat_i = 32'hA5A5A5A5;
    push(32'hA5A5A5A5, 1'b0);
    mid();
    chk("t4_gnt1", 64'(core_gnt), 64'd1);
    next(); core_req = 1'b0; wb_if.wb_ack = 1'b0; wb_if.wb_err = 1'b1;
    wb_if.wb_dat_i = 32'h5A5A5A5A;
    push(32'h5A5A5A5A, 1'b1);
    mid();
    chk("t4_rvalid_ok", 64'(core_rvalid), 64'd1);
    next(); wb_if.wb_err = 1'b0;
    mid();
    chk("t4_err2", 64'(core_err), 64'd1);

    // Ack and err together count as an error
    next(); core_req = 1'b1; core_addr = 32'h400;
    mid();
    next(); core_req = 1'b0; wb_if.wb_ack = 1'b1; wb_if.wb_err = 1'b1;
    wb_if.wb_dat_i = 32'h12345678;
    push(32'h12345678, 1'b1);
    mid();
    next(); wb_if.wb_ack = 1'b0; wb_if.wb_err = 1'b0;
    mid();
    chk("t4b_err", 64'(core_err), 64'd1);
    next();
    mid();
    chk_stats("t4");

    // Watchdog: two transfers, no ack, flush after 16 cycles
    next(); core_req = 1'b1; core_addr = 32'h500;
    mid();
    chk("t5_gnt0", 64'(core_gnt), 64'd1);
    next(); core_addr = 32'h504;
    mid();
    chk("t5_gnt1", 64'(core_gnt), 64'd1);
    next(); core_req = 1'b0;
    mid();
    for (int c = 3; c <= 16; c++) begin
      next();
      mid();
      chk("t5_cyc_wait", 64'(wb_if.wb_cyc), 64'd1);
      chk("t5_rvalid_wait", 64'(core_rvalid), 64'd0);
    end
    next(); core_req = 1'b1;
    push(32'h0, 1'b1);
    push(32'h0, 1'b1);
    exp_tmo++;
    mid();
    chk("t5_flush_cyc", 64'(wb_if.wb_cyc), 64'd0);
    chk("t5_flush_stb", 64'(wb_if.wb_stb), 64'd0);
    chk("t5_flush_gnt", 64'(core_gnt), 64'd0);
    next(); core_req = 1'b0; wb_if.wb_ack = 1'b1; wb_if.wb_dat_i = 32'hFFFF0000;
    mid();
    chk("t5_rvalid18", 64'(core_rvalid), 64'd1);
    next(); wb_if.wb_ack = 1'b0;
    mid();
    chk("t5_rvalid19", 64'(core_rvalid), 64'd1);
    next(); wb_if.wb_ack = 1'b1;
    mid();
    chk("t5_late_ack", 64'(core_rvalid), 64'd0);
    next(); wb_if.wb_ack = 1'b0;
    mid();
    chk("t5_idle_rvalid", 64'(core_rvalid), 64'd0);
    chk_stats("t5");

    // Reset with two outstanding
    next(); core_req = 1'b1; core_addr = 32'h600;
    mid();
    next(); core_addr = 32'h604;
    mid();
    chk("t6_gnt1", 64'(core_gnt), 64'd1);
    next(); core_req = 1'b0; rst_n = 1'b0;
    exp_txn = 0; exp_err = 0; exp_tmo = 0;
    mid();
    next(); rst_n = 1'b1; wb_if.wb_ack = 1'b1; wb_if.wb_dat_i = 32'h66666666;
    mid();
    chk("t6_cyc", 64'(wb_if.wb_cyc), 64'd0);
    chk("t6_rvalid", 64'(core_rvalid), 64'd0);
    next(); wb_if.wb_ack = 1'b0; core_req = 1'b1; core_addr = 32'h700;
    mid();
    chk("t6_spurious", 64'(core_rvalid), 64'd0);
    chk("t6_gnt_after", 64'(core_gnt), 64'd1);
    next(); core_req = 1'b0; wb_if.wb_ack = 1'b1; wb_if.wb_dat_i = 32'h77777777;
    push(32'h77777777, 1'b0);
    mid();
    next(); wb_if.wb_ack = 1'b0;
    mid();
    chk("t6_rvalid_after", 64'(core_rvalid), 64'd1);
    next();
    mid();
    chk_stats("t6");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
